// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with BCD/hex decode, leading-zero blanking
// and a double-buffered display value that only changes on frame boundaries.
module seg7_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter bit DIG_ACTIVE_LOW = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cs,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    hex_mode,
    input  logic                    lz_blank,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_done
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] CNT_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_ACTIVE_LOW}};

    logic [PW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d, act_val_q, act_val_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d, fd_q, fd_d;
    logic [NUM_DIGITS-1:0]   dig_q, dig_d;

    logic                  tc, wrap, all_zero;
    logic [3:0]            cur_code;
    logic [NUM_DIGITS-1:0] lz_vec;

    function automatic logic [6:0] decode7(input logic [3:0] c, input logic hex);
        logic [6:0] s;
        case (c)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return (!hex && c > 4'd9) ? 7'b0000000 : s;
    endfunction

    always_comb begin
        tc    = (cnt_q == CNT_LAST);
        wrap  = tc && (idx_q == IDX_LAST);
        cnt_d = tc ? '0 : cnt_q + PW'(1);
        idx_d = idx_q;
        if (tc) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);

        // Load on the boundary cycle bypasses straight into the active copy.
        pend_val_d = load ? value : pend_val_q;
        pend_dp_d  = load ? dp_in : pend_dp_q;
        act_val_d  = wrap ? pend_val_d : act_val_q;
        act_dp_d   = wrap ? pend_dp_d : act_dp_q;

        // lz_vec[k]: digit k and all more-significant digits are zero.
        all_zero = 1'b1;
        lz_vec   = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            all_zero  = all_zero && (act_val_q[4*k +: 4] == 4'd0);
            lz_vec[k] = all_zero;
        end
        lz_vec[0] = 1'b0;

        cur_code = act_val_q[4*int'(idx_q) +: 4];
        seg_d    = '0;
        dp_d     = 1'b0;
        dig_d    = DIG_OFF;
        if (cs) begin
            seg_d = (lz_blank && lz_vec[idx_q]) ? 7'b0000000 : decode7(cur_code, hex_mode);
            dp_d  = act_dp_q[idx_q];
            dig_d = (NUM_DIGITS'(1) << idx_q) ^ DIG_OFF;
        end
        fd_d = wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            act_val_q  <= '0;
            act_dp_q   <= '0;
            seg_q      <= '0;
            dp_q       <= 1'b0;
            dig_q      <= DIG_OFF;
            fd_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            act_val_q  <= act_val_d;
            act_dp_q   <= act_dp_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            dig_q      <= dig_d;
            fd_q       <= fd_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign dig_en     = dig_q;
    assign frame_done = fd_q;
endmodule
